full_adder_reg: RTL and testbench
=================================

// Module: full_adder_reg
// PURPOSE
// - Registered 1-bit full adder: sums a, b and carry_in and presents sum/carry_out from flops.
// - Leaf arithmetic cell for ripple/serial adder chains.
// - Also the target for the team's formal cover/assert flow, so it carries embedded `ifdef FORMAL checks.
// - One clock domain, no handshake; a fresh operand set is accepted every cycle.
// PARAMETERS
// - none (fixed 1-bit datapath; width extension is done by chaining instances)
// PORTS
// - clk        input   1  single clock; all state updates on posedge clk
// - rstn       input   1  synchronous, active-HIGH reset (name kept per codebase; 1 = reset)
// - a          input   1  operand A
// - b          input   1  operand B
// - carry_in   input   1  carry from less-significant stage
// - sum        output  1  registered a^b^carry_in
// - carry_out  output  1  registered (a&b)|(a&carry_in)|(b&carry_in)
// - out_valid  output  1  1 once a non-reset cycle has been captured into sum/carry_out
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset:
//   - rstn sampled 1 at posedge -> sum=0, carry_out=0, out_valid=0 after that edge.
//   - Inputs are ignored while rstn=1.
//   - Power-up flop values are unspecified until the first reset edge.
// - Normal operation (rstn=0 at posedge):
//   - sum <= a^b^carry_in
//   - carry_out <= majority(a,b,carry_in)
//   - out_valid <= 1
// - Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
// - Throughput: 1 result per cycle. Each edge overwrites the previous result; there is no hold/enable.
// - Arithmetic: {carry_out,sum} == a+b+carry_in (2-bit result, range 0..3); no overflow possible.
// - Reset mid-stream: the result registered before the reset edge is discarded. The cycle after
//   rstn falls, the outputs reflect the inputs sampled at that first non-reset edge.
// - No combinational path from inputs to outputs.
// - Formal (`ifdef FORMAL only, excluded from synthesis):
//   - past_valid flag.
//   - Assert: if past_valid && !$past(rstn), then {carry_out,sum} == $past(a)+$past(b)+$past(carry_in).
//   - Assert: if past_valid && $past(rstn), then sum==0, carry_out==0, out_valid==0.
//   - Assert: carry_out implies !(sum && !$past(a) && !$past(b)) for non-reset cycles.
//   - Cover: each of the 8 input combinations and each of the 4 output codes.
// TESTING
// - Reset: rstn=1, a=0, b=1, carry_in=0 for 2 cycles -> sum=0, carry_out=0, out_valid=0 every cycle.
// - Exhaustive sweep: rstn=0, drive all 8 {a,b,cin} combos one per cycle -> next cycle
//   {carry_out,sum} = a+b+cin (e.g. 1,1,1 -> 2'b11; 1,0,0 -> 2'b01); out_valid=1.
// - Latency: a=1, b=1, cin=0 at edge N, then all-zero inputs -> after N carry_out=1, sum=0;
//   after N+1 both 0.
// - Reset mid-stream: result 2'b11 pending, assert rstn for 1 cycle -> outputs 0, out_valid=0;
//   deassert with a=0, b=1, cin=1 -> next cycle 2'b10, out_valid=1.
// - Back-to-back toggling: alternate 0,0,0 and 1,1,1 each cycle -> outputs alternate 2'b00/2'b11
//   with 1-cycle lag.
// - Formal: run prove + cover; all asserts pass, all 12 covers reached within depth 4.

Source files
------------

// File: rtl/full_adder_reg_if.sv
// full_adder_reg_if: operand and result bundle for one registered full-adder cell.
//   a, b, carry_in           operands, driven by the master
//   sum, carry_out           registered result bits, driven by the slave (the adder)
//   out_valid                high once a non-reset cycle has been captured
// Clock and reset are plain ports on the adder, not part of this bundle.
interface full_adder_reg_if;
    logic a;
    logic b;
    logic carry_in;
    logic sum;
    logic carry_out;
    logic out_valid;

    modport master (
        output a, b, carry_in,
        input  sum, carry_out, out_valid
    );

    modport slave (
        input  a, b, carry_in,
        output sum, carry_out, out_valid
    );
endinterface

// File: rtl/full_adder_reg.sv
// full_adder_reg: registered 1-bit full adder, leaf cell for ripple/serial adder chains.
// Ports:
//   clk    input   single clock, all state updates on posedge
//   rstn   input   synchronous reset, active HIGH despite the name (1 = reset)
//   bus    slave   a, b, carry_in in; sum, carry_out, out_valid out (all outputs registered)
// One result per cycle, latency exactly one cycle, no combinational input-to-output path.
module full_adder_reg (
    input  logic               clk,
    input  logic               rstn,
    full_adder_reg_if.slave    bus
);

    logic w_sum;
    logic w_carry;
    logic r_sum;
    logic r_carry;
    logic r_valid;

    always_comb begin
        w_sum   = bus.a ^ bus.b ^ bus.carry_in;
        w_carry = (bus.a & bus.b) | (bus.a & bus.carry_in) | (bus.b & bus.carry_in);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_sum   <= 1'b0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
            r_valid <= 1'b1;
        end
    end

    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry;
    assign bus.out_valid = r_valid;

`ifdef FORMAL
    logic f_past_valid = 1'b0;

    always_ff @(posedge clk) begin
        f_past_valid <= 1'b1;
    end

    always @(posedge clk) begin
        if (f_past_valid && !$past(rstn)) begin
            assert ({bus.carry_out, bus.sum} ==
                    {1'b0, $past(bus.a)} + {1'b0, $past(bus.b)} + {1'b0, $past(bus.carry_in)});
            // A carry with sum set needs at least two ones among the operands,
            // which rules out a and b both having been zero.
            assert (!(bus.carry_out && bus.sum && !$past(bus.a) && !$past(bus.b)));
        end
        if (f_past_valid && $past(rstn)) begin
            assert (bus.sum == 1'b0 && bus.carry_out == 1'b0 && bus.out_valid == 1'b0);
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_cov_in
        always @(posedge clk) begin
            if (!rstn) cover ({bus.a, bus.b, bus.carry_in} == 3'(gi));
        end
    end

    for (genvar go = 0; go < 4; go++) begin : g_cov_out
        always @(posedge clk) begin
            if (f_past_valid && !$past(rstn)) cover ({bus.carry_out, bus.sum} == 2'(go));
        end
    end
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// tb_full_adder_reg: directed bench for full_adder_reg with a scoreboard queue of
// expected {out_valid, carry_out, sum} values.
module tb_full_adder_reg;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    logic [2:0] sb_q[$];
    logic [2:0] last_exp;

    full_adder_reg_if bus ();

    full_adder_reg u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive one operand set, queue its expected result, then pop and check after the edge.
    task automatic step(input string tag, input logic r, input logic x, input logic y, input logic z);
        logic [1:0] total_bits;
        logic [2:0] exp;
        rstn         = r;
        bus.a        = x;
        bus.b        = y;
        bus.carry_in = z;
        total_bits   = 2'(x) + 2'(y) + 2'(z);
        sb_q.push_back(r ? 3'b000 : {1'b1, total_bits});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            compare({tag, "_queue"}, 3'b001, 3'b000);
        end else begin
            exp = sb_q.pop_front();
            last_exp = exp;
            compare(tag, {bus.out_valid, bus.carry_out, bus.sum}, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_exp = 3'b000;

        step("reset0", 1'b1, 1'b0, 1'b1, 1'b0);
        step("reset1", 1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step($sformatf("sweep%0d", i), 1'b0, v[2], v[1], v[0]);
        end

        step("lat_n",  1'b0, 1'b1, 1'b1, 1'b0);
        step("lat_n1", 1'b0, 1'b0, 1'b0, 1'b0);

        step("mid_pend",  1'b0, 1'b1, 1'b1, 1'b1);
        step("mid_rst",   1'b1, 1'b1, 1'b1, 1'b1);
        step("mid_after", 1'b0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            logic t;
            t = (i % 2 == 1);
            step($sformatf("toggle%0d", i), 1'b0, t, t, t);
        end

        // Outputs must not follow inputs between edges.
        bus.a        = 1'b0;
        bus.b        = 1'b0;
        bus.carry_in = 1'b0;
        #2;
        compare("no_comb", {bus.out_valid, bus.carry_out, bus.sum}, last_exp);

        compare("sb_empty", 3'(sb_q.size()), 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
